id_ex_pipe_stage: RTL and testbench



---
 rtl/id_ex_pipe_stage_pkg.sv | 29 ++
 rtl/id_ex_pipe_stage_skid.sv | 95 +++++++++
 rtl/id_ex_pipe_stage.sv | 91 +++++++++
 tb/tb_id_ex_pipe_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_stage_pkg.sv
// id_ex_pipe_stage_pkg
//   Pipeline-wide definitions shared by the ID/EX boundary: ALU operation
//   encodings, control-bundle bit positions and the canonical NOP control
//   word. No ports; imported with `import id_ex_pipe_stage_pkg::*;`.
package id_ex_pipe_stage_pkg;

   // ALU control encoding (classic 4-bit MIPS-style ALU control field).
   localparam int ALU_OP_W = 4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 4'b0000;
   localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 4'b0001;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'b0010;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'b0110;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SLT = 4'b0111;
   localparam logic [ALU_OP_W-1:0] ALU_OP_NOR = 4'b1100;

   // Control bundle bit positions.
   localparam int CTRL_W          = 7;
   localparam int CTRL_MEM_READ   = 0;
   localparam int CTRL_MEM_WRITE  = 1;
   localparam int CTRL_MEM_TO_REG = 2;
   localparam int CTRL_REG_WRITE  = 3;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_BRANCH     = 5;
   localparam int CTRL_JUMP       = 6;

   // A bubble: ADD with the immediate selected, no side effects.
   localparam logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(1) << CTRL_ALU_SRC;

endpackage

// File: rtl/id_ex_pipe_stage_skid.sv
// pipe_skid_buf
//   Generic elastic register pair carrying a W-bit payload with valid/ready
//   handshakes on both sides. The main entry drives out_data straight from
//   flops. With SKID_EN != 0 a second (skid) entry catches the word accepted
//   while the main entry is stalled, so in_ready is a pure flop output; with
//   SKID_EN == 0 only the main entry exists and in_ready is combinational.
//   When the main entry empties it is loaded with IDLE.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             synchronous kill of every held entry
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
module pipe_skid_buf #(
   parameter int             W       = 8,
   parameter int             SKID_EN = 1,
   parameter logic [W-1:0]   IDLE    = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid;
   logic [W-1:0] main_data;
   logic         skid_valid;
   logic [W-1:0] skid_data;
   logic         accept;
   logic         fire;
   logic         main_load;

   assign accept    = in_valid & in_ready;
   assign fire      = main_valid & out_ready;
   assign main_load = ~main_valid | fire;

   assign out_valid = main_valid;
   assign out_data  = main_data;

   // Main entry: skid has priority so acceptance order is preserved.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_data  <= IDLE;
      end else if (clear) begin
         main_valid <= 1'b0;
         main_data  <= IDLE;
      end else if (main_load) begin
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
         end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
         end else begin
            main_valid <= 1'b0;
            main_data  <= IDLE;
         end
      end
   end

   generate
      if (SKID_EN != 0) begin : g_skid
         // Whenever main loads, the skid is either drained into main or was
         // already empty (in which case an accept went to main instead).
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_valid <= 1'b0;
            end else if (clear || main_load) begin
               skid_valid <= 1'b0;
            end else if (accept) begin
               skid_valid <= 1'b1;
            end
         end

         // Payload only; its validity is tracked by skid_valid.
         always_ff @(posedge clk) begin
            if (accept && !main_load) begin
               skid_data <= in_data;
            end
         end

         assign in_ready = ~skid_valid;
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_data  = IDLE;
         assign in_ready   = main_load;
      end
   endgenerate

endmodule

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage
//   ID/EX pipeline boundary. Packs the decoded instruction into one payload,
//   holds it in an elastic register pair (optional skid entry), substitutes
//   the canonical NOP whenever no instruction is held, kills everything on
//   flush and counts back-pressure cycles.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid, in_ready       decode-side handshake
//   flush                    synchronous kill of all held entries
//   pc, immd, data1, data2, rs1, rs2, rd, alu_op, ctrl   decoded fields in
//   out_valid, out_ready     execute-side handshake
//   *_out                    registered fields (NOP values when idle)
//   stall_cnt                saturating count of out_valid & ~out_ready cycles
module id_ex_pipe_stage
   import id_ex_pipe_stage_pkg::*;
#(
   parameter int  WORD_SIZE = 32,
   parameter int  ADDR_SIZE = 10,
   parameter int  NUM_REGS  = 32,
   parameter int  SKID_EN   = 1,
   parameter int  CNT_W     = 16,
   localparam int REG_SEL   = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   input  logic [ADDR_SIZE-1:0] pc,
   input  logic [WORD_SIZE-1:0] immd,
   input  logic [WORD_SIZE-1:0] data1,
   input  logic [WORD_SIZE-1:0] data2,
   input  logic [REG_SEL-1:0]   rs1,
   input  logic [REG_SEL-1:0]   rs2,
   input  logic [REG_SEL-1:0]   rd,
   input  logic [ALU_OP_W-1:0]  alu_op,
   input  logic [CTRL_W-1:0]    ctrl,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ADDR_SIZE-1:0] pc_out,
   output logic [WORD_SIZE-1:0] immd_out,
   output logic [WORD_SIZE-1:0] data1_out,
   output logic [WORD_SIZE-1:0] data2_out,
   output logic [REG_SEL-1:0]   rs1_out,
   output logic [REG_SEL-1:0]   rs2_out,
   output logic [REG_SEL-1:0]   rd_out,
   output logic [ALU_OP_W-1:0]  alu_op_out,
   output logic [CTRL_W-1:0]    ctrl_out,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam int PAY_W = ADDR_SIZE + 3*WORD_SIZE + 3*REG_SEL + ALU_OP_W + CTRL_W;

   // Idle payload: every field zero except the ALU op and control word.
   localparam logic [PAY_W-1:0] NOP_PAYLOAD =
      {{(PAY_W-ALU_OP_W-CTRL_W){1'b0}}, ALU_OP_ADD, CTRL_NOP};

   logic [PAY_W-1:0] in_payload;
   logic [PAY_W-1:0] out_payload;

   assign in_payload = {pc, immd, data1, data2, rs1, rs2, rd, alu_op, ctrl};

   pipe_skid_buf #(
      .W       (PAY_W),
      .SKID_EN (SKID_EN),
      .IDLE    (NOP_PAYLOAD)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_payload),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_payload)
   );

   assign {pc_out, immd_out, data1_out, data2_out,
           rs1_out, rs2_out, rd_out, alu_op_out, ctrl_out} = out_payload;

   // Back-pressure counter; survives flush, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
module tb_id_ex_pipe_stage;
   import id_ex_pipe_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT A: skid present, 4-bit stall counter
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [9:0]  pc, pc_out;
   logic [31:0] immd, data1, data2, immd_out, data1_out, data2_out;
   logic [4:0]  rs1, rs2, rd, rs1_out, rs2_out, rd_out;
   logic [3:0]  alu_op, alu_op_out;
   logic [6:0]  ctrl, ctrl_out;
   logic [3:0]  stall_cnt;

   // DUT B: no skid
   logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b;
   logic [9:0]  pc_b, pc_out_b;
   logic [31:0] immd_b, data1_b, data2_b, immd_out_b, data1_out_b, data2_out_b;
   logic [4:0]  rs1_b, rs2_b, rd_b, rs1_out_b, rs2_out_b, rd_out_b;
   logic [3:0]  alu_op_b, alu_op_out_b;
   logic [6:0]  ctrl_b, ctrl_out_b;
   logic [3:0]  stall_cnt_b;

   id_ex_pipe_stage #(.SKID_EN(1), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .pc(pc), .immd(immd), .data1(data1), .data2(data2), .rs1(rs1), .rs2(rs2), .rd(rd),
      .alu_op(alu_op), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .pc_out(pc_out), .immd_out(immd_out), .data1_out(data1_out), .data2_out(data2_out),
      .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .alu_op_out(alu_op_out),
      .ctrl_out(ctrl_out), .stall_cnt(stall_cnt));

   id_ex_pipe_stage #(.SKID_EN(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .flush(flush_b),
      .pc(pc_b), .immd(immd_b), .data1(data1_b), .data2(data2_b), .rs1(rs1_b), .rs2(rs2_b),
      .rd(rd_b), .alu_op(alu_op_b), .ctrl(ctrl_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .pc_out(pc_out_b), .immd_out(immd_out_b),
      .data1_out(data1_out_b), .data2_out(data2_out_b), .rs1_out(rs1_out_b),
      .rs2_out(rs2_out_b), .rd_out(rd_out_b), .alu_op_out(alu_op_out_b),
      .ctrl_out(ctrl_out_b), .stall_cnt(stall_cnt_b));

   int total = 0;
   int bad   = 0;
   logic [9:0] q[$];
   logic [9:0] q_b[$];
   logic [9:0] e_a, e_b;

   // Field encoding of a test instruction, derived from its pc.
   function automatic logic [31:0] f_immd(input logic [9:0] p);  return 32'(p) ^ 32'hA5A5_0000; endfunction
   function automatic logic [31:0] f_data1(input logic [9:0] p); return 32'h1000_0000 + 32'(p); endfunction
   function automatic logic [31:0] f_data2(input logic [9:0] p); return ~32'(p); endfunction
   function automatic logic [4:0]  f_rs1(input logic [9:0] p);   return p[4:0]; endfunction
   function automatic logic [4:0]  f_rs2(input logic [9:0] p);   return ~p[4:0]; endfunction
   function automatic logic [4:0]  f_rd(input logic [9:0] p);    return p[4:0] + 5'd1; endfunction
   function automatic logic [3:0]  f_alu(input logic [9:0] p);   return p[3:0] ^ 4'h6; endfunction
   function automatic logic [6:0]  f_ctrl(input logic [9:0] p);  return p[6:0] ^ 7'h55; endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic drive(input logic [9:0] p);
      pc = p; immd = f_immd(p); data1 = f_data1(p); data2 = f_data2(p);
      rs1 = f_rs1(p); rs2 = f_rs2(p); rd = f_rd(p); alu_op = f_alu(p); ctrl = f_ctrl(p);
   endtask

   task automatic drive_b(input logic [9:0] p);
      pc_b = p; immd_b = f_immd(p); data1_b = f_data1(p); data2_b = f_data2(p);
      rs1_b = f_rs1(p); rs2_b = f_rs2(p); rd_b = f_rd(p); alu_op_b = f_alu(p); ctrl_b = f_ctrl(p);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor A: scoreboard pop on every fire, NOP check when idle.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected_out pc_out=%0h required=none", pc_out);
         end else begin
            e_a = q.pop_front();
            chk("a_pc_out", 64'(pc_out), 64'(e_a));
            chk("a_immd_out", 64'(immd_out), 64'(f_immd(e_a)));
            chk("a_data1_out", 64'(data1_out), 64'(f_data1(e_a)));
            chk("a_data2_out", 64'(data2_out), 64'(f_data2(e_a)));
            chk("a_regs_out", 64'({rs1_out, rs2_out, rd_out}),
                64'({f_rs1(e_a), f_rs2(e_a), f_rd(e_a)}));
            chk("a_alu_ctrl_out", 64'({alu_op_out, ctrl_out}), 64'({f_alu(e_a), f_ctrl(e_a)}));
         end
      end else if (!rst && !out_valid) begin
         chk("a_idle_nop", 64'({pc_out, alu_op_out, ctrl_out, data1_out}),
             64'({10'd0, ALU_OP_ADD, CTRL_NOP, 32'd0}));
      end
   end

   // Monitor B
   always @(negedge clk) begin
      if (!rst && out_valid_b && out_ready_b) begin
         if (q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_out pc_out=%0h required=none", pc_out_b);
         end else begin
            e_b = q_b.pop_front();
            chk("b_pc_out", 64'(pc_out_b), 64'(e_b));
            chk("b_immd_out", 64'(immd_out_b), 64'(f_immd(e_b)));
            chk("b_data_out", 64'({data1_out_b, data2_out_b}), {f_data1(e_b), f_data2(e_b)});
            chk("b_fields_out", 64'({rs1_out_b, rs2_out_b, rd_out_b, alu_op_out_b, ctrl_out_b}),
                64'({f_rs1(e_b), f_rs2(e_b), f_rd(e_b), f_alu(e_b), f_ctrl(e_b)}));
         end
      end else if (!rst && !out_valid_b) begin
         chk("b_idle_nop", 64'({pc_out_b, alu_op_out_b, ctrl_out_b}),
             64'({10'd0, ALU_OP_ADD, CTRL_NOP}));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; drive(10'd0);
      in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b0; drive_b(10'd0);
      tick; tick;
      rst = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_alu_op", 64'(alu_op_out), 64'(ALU_OP_ADD));
      chk("rst_ctrl", 64'(ctrl_out), 64'(CTRL_NOP));
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_fields", 64'({pc_out, rd_out, immd_out}), 64'd0);

      // Streaming, 1-cycle latency, no stalls
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(10'(i)); in_valid = 1'b1; q.push_back(10'(i));
         chk("stream_in_ready", 64'(in_ready), 64'd1);
         tick;
         chk("stream_pc_out", 64'({out_valid, pc_out}), 64'({1'b1, 10'(i)}));
      end
      in_valid = 1'b0;
      tick;
      chk("stream_drained", 64'(out_valid), 64'd0);

      // Back-pressure with skid
      drive(10'h10); in_valid = 1'b1; q.push_back(10'h10);
      tick;
      out_ready = 1'b0;
      drive(10'h11); q.push_back(10'h11);
      chk("bp_in_ready_before_skid", 64'(in_ready), 64'd1);
      chk("bp_pc_out_b", 64'(pc_out), 64'h10);
      tick;
      drive(10'h12);
      chk("bp_in_ready_skid_full", 64'(in_ready), 64'd0);
      chk("bp_pc_out_c", 64'(pc_out), 64'h10);
      tick;
      chk("bp_in_ready_d", 64'(in_ready), 64'd0);
      chk("bp_pc_out_d", 64'(pc_out), 64'h10);
      tick;
      chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);
      chk("bp_hold_fields", 64'({pc_out, data1_out}), 64'({10'h10, f_data1(10'h10)}));
      out_ready = 1'b1;
      tick;
      chk("bp_release_pc", 64'(pc_out), 64'h11);
      q.push_back(10'h12);
      tick;
      in_valid = 1'b0;
      chk("bp_last_pc", 64'(pc_out), 64'h12);
      tick;
      chk("bp_stall_cnt_kept", 64'(stall_cnt), 64'd3);

      // Flush with skid full; 0x20 offered but never delivered
      out_ready = 1'b0;
      drive(10'h1A); in_valid = 1'b1;
      tick;
      drive(10'h1B);
      tick;
      drive(10'h20); flush = 1'b1;
      tick;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_nop", 64'({pc_out, alu_op_out, ctrl_out}), 64'({10'd0, ALU_OP_ADD, CTRL_NOP}));
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_keeps_stall_cnt", 64'(stall_cnt), 64'd5);

      // Flush discards an instruction accepted in the same cycle
      drive(10'h22); in_valid = 1'b1;
      tick;
      drive(10'h21); flush = 1'b1;
      chk("flush_accept_in_ready", 64'(in_ready), 64'd1);
      tick;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("flush_accept_discarded", 64'(out_valid), 64'd0);
      repeat (3) tick;
      chk("flush_stays_empty", 64'(out_valid), 64'd0);

      // Flush concurrent with fire: consumed once, then bubble
      drive(10'h30); in_valid = 1'b1; q.push_back(10'h30);
      tick;
      in_valid = 1'b0; flush = 1'b1;
      chk("ff_presented", 64'({out_valid, pc_out}), 64'({1'b1, 10'h30}));
      tick;
      flush = 1'b0;
      chk("ff_bubble", 64'(out_valid), 64'd0);
      tick;
      chk("ff_bubble2", 64'(out_valid), 64'd0);

      // Counter saturation
      out_ready = 1'b0;
      drive(10'h40); in_valid = 1'b1; q.push_back(10'h40);
      tick;
      in_valid = 1'b0;
      repeat (20) tick;
      chk("sat_stall_cnt", 64'(stall_cnt), 64'd15);
      out_ready = 1'b1;
      tick;
      chk("sat_stall_cnt_hold", 64'(stall_cnt), 64'd15);
      chk("sat_drained", 64'(out_valid), 64'd0);

      // No-skid variant: streaming
      out_ready_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive_b(10'(i)); in_valid_b = 1'b1; q_b.push_back(10'(i));
         chk("b_stream_in_ready", 64'(in_ready_b), 64'd1);
         tick;
         chk("b_stream_pc_out", 64'({out_valid_b, pc_out_b}), 64'({1'b1, 10'(i)}));
      end
      in_valid_b = 1'b0;
      tick;

      // No-skid variant: in_ready follows out_ready combinationally
      drive_b(10'h10); in_valid_b = 1'b1; q_b.push_back(10'h10);
      tick;
      out_ready_b = 1'b0; drive_b(10'h11);
      #1;
      chk("b_in_ready_low", 64'(in_ready_b), 64'd0);
      tick;
      chk("b_hold_pc", 64'(pc_out_b), 64'h10);
      out_ready_b = 1'b1;
      #1;
      chk("b_in_ready_high", 64'(in_ready_b), 64'd1);
      q_b.push_back(10'h11);
      tick;
      drive_b(10'h12); q_b.push_back(10'h12);
      tick;
      in_valid_b = 1'b0;
      tick;
      tick;
      chk("b_stall_cnt", 64'(stall_cnt_b), 64'd1);

      // Asynchronous reset mid-stream with the skid full
      out_ready = 1'b0;
      drive(10'h50); in_valid = 1'b1;
      tick;
      drive(10'h51);
      tick;
      in_valid = 1'b0;
      chk("pre_rst_skid_full", 64'(in_ready), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_nop", 64'({alu_op_out, ctrl_out, pc_out}), 64'({ALU_OP_ADD, CTRL_NOP, 10'd0}));
      chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      tick;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick;
      chk("arst_nothing_survives", 64'(out_valid), 64'd0);
      drive(10'h60); in_valid = 1'b1; q.push_back(10'h60);
      tick;
      in_valid = 1'b0;
      chk("post_rst_pc", 64'({out_valid, pc_out}), 64'({1'b1, 10'h60}));
      tick;
      tick;

      chk("a_queue_drained", 64'(q.size()), 64'd0);
      chk("b_queue_drained", 64'(q_b.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
